// File: rtl/decode_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe_pkg
// Brief    : uDLX decode constants, decoded-bundle type and its NOP default.
// Revision : 1.0 - initial release
// ============================================================================
package decode_stage_pipe_pkg;

  localparam int INSTR_W      = 32;
  localparam int DATA_W       = 32;
  localparam int OPCODE_W     = 6;
  localparam int FUNC_W       = 6;
  localparam int REG_W        = 5;
  localparam int IMM_W        = 16;
  localparam int PCOFF_W      = 26;
  localparam int BUBBLE_CNT_W = 16;

  localparam logic [OPCODE_W-1:0] R_TYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] JPC    = 6'h02;
  localparam logic [OPCODE_W-1:0] BEQZ   = 6'h04;
  localparam logic [OPCODE_W-1:0] BNEZ   = 6'h05;
  localparam logic [OPCODE_W-1:0] BRFL   = 6'h06;
  localparam logic [OPCODE_W-1:0] ADDI   = 6'h08;
  localparam logic [OPCODE_W-1:0] SUBI   = 6'h0A;
  localparam logic [OPCODE_W-1:0] ANDI   = 6'h0C;
  localparam logic [OPCODE_W-1:0] ORI    = 6'h0D;
  localparam logic [OPCODE_W-1:0] JR     = 6'h12;
  localparam logic [OPCODE_W-1:0] LW     = 6'h23;
  localparam logic [OPCODE_W-1:0] SW     = 6'h2B;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic                rd_en1;
    logic                rd_en2;
    logic [REG_W-1:0]    rd;
    logic                wr_en;
    logic [DATA_W-1:0]   imm;
    logic                imm_inst;
    logic [DATA_W-1:0]   pc_off;
    logic                mem_rd;
    logic                mem_wr;
    logic                wb_sel;
    logic                branch;
    logic                jump;
    logic                jump_r;
    logic                illegal;
  } bundle_t;

  localparam bundle_t NOP_BUNDLE = '0;

endpackage : decode_stage_pipe_pkg
`default_nettype wire

// File: rtl/decode_stage_pipe_decode_fields.sv
`default_nettype none
// ============================================================================
// Module   : decode_fields
// Brief    : Combinational uDLX opcode-to-bundle decoder with sign extension.
// Revision : 1.0 - initial release
// ============================================================================
import decode_stage_pipe_pkg::*;

module decode_fields #(
  parameter int INSTRUCTION_WIDTH = INSTR_W,
  parameter int DATA_WIDTH        = DATA_W,
  parameter int OPCODE_WIDTH      = OPCODE_W,
  parameter int FUNCTION_WIDTH    = FUNC_W,
  parameter int REG_ADDR_WIDTH    = REG_W,
  parameter int IMEDIATE_WIDTH    = IMM_W,
  parameter int PC_OFFSET_WIDTH   = PCOFF_W
) (
  input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
  output bundle_t                      o_bundle
);

  localparam int c_RS1_MSB = INSTRUCTION_WIDTH - OPCODE_WIDTH - 1;
  localparam int c_RS2_MSB = c_RS1_MSB - REG_ADDR_WIDTH;
  localparam int c_RD_MSB  = c_RS2_MSB - REG_ADDR_WIDTH;

  logic [OPCODE_WIDTH-1:0]   w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rs1;
  logic [REG_ADDR_WIDTH-1:0] w_rs2;
  logic [REG_ADDR_WIDTH-1:0] w_rd_r;
  logic [DATA_WIDTH-1:0]     w_imm_sext;
  logic [DATA_WIDTH-1:0]     w_pcoff_sext;

  assign w_opcode     = i_instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign w_rs1        = i_instruction[c_RS1_MSB -: REG_ADDR_WIDTH];
  assign w_rs2        = i_instruction[c_RS2_MSB -: REG_ADDR_WIDTH];
  assign w_rd_r       = i_instruction[c_RD_MSB -: REG_ADDR_WIDTH];
  assign w_imm_sext   = {{(DATA_WIDTH-IMEDIATE_WIDTH){i_instruction[IMEDIATE_WIDTH-1]}},
                         i_instruction[IMEDIATE_WIDTH-1:0]};
  assign w_pcoff_sext = {{(DATA_WIDTH-PC_OFFSET_WIDTH){i_instruction[PC_OFFSET_WIDTH-1]}},
                         i_instruction[PC_OFFSET_WIDTH-1:0]};

  always_comb begin
    o_bundle        = NOP_BUNDLE;
    o_bundle.opcode = w_opcode;
    case (w_opcode)
      R_TYPE: begin
        // The all-zero word shares the R-type opcode but is the canonical NOP.
        if (i_instruction != '0) begin
          o_bundle.func   = i_instruction[FUNCTION_WIDTH-1:0];
          o_bundle.rs1    = w_rs1;
          o_bundle.rs2    = w_rs2;
          o_bundle.rd     = w_rd_r;
          o_bundle.rd_en1 = 1'b1;
          o_bundle.rd_en2 = 1'b1;
          o_bundle.wr_en  = 1'b1;
        end
      end
      ADDI, SUBI, ANDI, ORI, LW: begin
        o_bundle.rs1      = w_rs1;
        o_bundle.rd_en1   = 1'b1;
        o_bundle.rd       = w_rs2;
        o_bundle.wr_en    = 1'b1;
        o_bundle.imm      = w_imm_sext;
        o_bundle.imm_inst = 1'b1;
        o_bundle.mem_rd   = (w_opcode == LW);
        o_bundle.wb_sel   = (w_opcode == LW);
      end
      SW: begin
        o_bundle.rs1      = w_rs1;
        o_bundle.rs2      = w_rs2;
        o_bundle.rd_en1   = 1'b1;
        o_bundle.rd_en2   = 1'b1;
        o_bundle.imm      = w_imm_sext;
        o_bundle.imm_inst = 1'b1;
        o_bundle.mem_wr   = 1'b1;
      end
      BEQZ, BNEZ, BRFL: begin
        o_bundle.rs1    = w_rs1;
        o_bundle.rd_en1 = 1'b1;
        o_bundle.imm    = w_imm_sext;
        o_bundle.branch = 1'b1;
      end
      JR: begin
        o_bundle.rs1    = w_rs1;
        o_bundle.rd_en1 = 1'b1;
        o_bundle.jump   = 1'b1;
        o_bundle.jump_r = 1'b1;
      end
      JPC: begin
        o_bundle.pc_off = w_pcoff_sext;
        o_bundle.jump   = 1'b1;
      end
      default: o_bundle.illegal = 1'b1;
    endcase
  end

endmodule : decode_fields
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Brief    : Registered valid/ready uDLX decode stage with flush and load-use
//            interlock (interlock enabled by UDLX_LOAD_USE_INTERLOCK_EN).
// Revision : 1.0 - initial release
// ============================================================================
import decode_stage_pipe_pkg::*;

module decode_stage_pipe #(
  parameter int INSTRUCTION_WIDTH = INSTR_W,
  parameter int DATA_WIDTH        = DATA_W,
  parameter int OPCODE_WIDTH      = OPCODE_W,
  parameter int FUNCTION_WIDTH    = FUNC_W,
  parameter int REG_ADDR_WIDTH    = REG_W,
  parameter int IMEDIATE_WIDTH    = IMM_W,
  parameter int PC_OFFSET_WIDTH   = PCOFF_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [DATA_WIDTH-1:0]        pc_in,
  input  logic                         flush_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        pc_out,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_rd_addr1_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_rd_addr2_out,
  output logic                         reg_rd_en1_out,
  output logic                         reg_rd_en2_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         reg_wr_en_out,
  output logic [DATA_WIDTH-1:0]        immediate_out,
  output logic                         imm_inst_out,
  output logic [DATA_WIDTH-1:0]        pc_offset_out,
  output logic                         mem_data_rd_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic                         jump_use_r_out,
  output logic                         illegal_inst_out,
  output logic [BUBBLE_CNT_W-1:0]      bubble_count_out
);

  bundle_t               w_dec;
  bundle_t               r_bundle;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  w_advance;
  logic                  w_hazard;
  logic                  w_accept;

  decode_fields #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .OPCODE_WIDTH      (OPCODE_WIDTH),
    .FUNCTION_WIDTH    (FUNCTION_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
    .IMEDIATE_WIDTH    (IMEDIATE_WIDTH),
    .PC_OFFSET_WIDTH   (PC_OFFSET_WIDTH)
  ) u_decode_fields (
    .i_instruction (instruction_in),
    .o_bundle      (w_dec)
  );

  assign w_advance = !r_valid || out_ready;

`ifdef UDLX_LOAD_USE_INTERLOCK_EN
  logic                    w_src_match;
  logic [BUBBLE_CNT_W-1:0] r_bubble_count;

  assign w_src_match = (w_dec.rd_en1 && (w_dec.rs1 == r_bundle.rd)) ||
                       (w_dec.rd_en2 && (w_dec.rs2 == r_bundle.rd));
  assign w_hazard    = r_valid && r_bundle.mem_rd && (r_bundle.rd != '0) &&
                       in_valid && w_src_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (!flush_in && w_advance && w_hazard && (r_bubble_count != '1)) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign bubble_count_out = r_bubble_count;
`else
  assign w_hazard         = 1'b0;
  assign bubble_count_out = '0;
`endif

  // Flush keeps the port open so the squashed fetch drains in the same cycle.
  assign in_ready = !rst && (flush_in || (w_advance && !w_hazard));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      r_valid  <= 1'b0;
      r_bundle <= NOP_BUNDLE;
      r_pc     <= '0;
    end else if (w_advance) begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_bundle <= w_dec;
        r_pc     <= pc_in;
      end else begin
        r_valid  <= 1'b0;
        r_bundle <= NOP_BUNDLE;
        r_pc     <= '0;
      end
    end
  end

  assign out_valid              = r_valid;
  assign pc_out                 = r_pc;
  assign opcode_out             = r_bundle.opcode;
  assign inst_function_out      = r_bundle.func;
  assign reg_rd_addr1_out       = r_bundle.rs1;
  assign reg_rd_addr2_out       = r_bundle.rs2;
  assign reg_rd_en1_out         = r_bundle.rd_en1;
  assign reg_rd_en2_out         = r_bundle.rd_en2;
  assign reg_wr_addr_out        = r_bundle.rd;
  assign reg_wr_en_out          = r_bundle.wr_en;
  assign immediate_out          = r_bundle.imm;
  assign imm_inst_out           = r_bundle.imm_inst;
  assign pc_offset_out          = r_bundle.pc_off;
  assign mem_data_rd_en_out     = r_bundle.mem_rd;
  assign mem_data_wr_en_out     = r_bundle.mem_wr;
  assign write_back_mux_sel_out = r_bundle.wb_sel;
  assign branch_inst_out        = r_bundle.branch;
  assign jump_inst_out          = r_bundle.jump;
  assign jump_use_r_out         = r_bundle.jump_r;
  assign illegal_inst_out       = r_bundle.illegal;

endmodule : decode_stage_pipe
`default_nettype wire

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Registered, flow-controlled instruction decode stage for the uDLX core. Sits between the fetch/IF-ID register and the execute stage. Decodes one instruction per cycle into a widened control and operand bundle with sign-extended immediates. Uses a valid/ready handshake, load-use interlock, flush and an illegal-opcode flag.

## Interface
- INSTRUCTION_WIDTH, 32, instruction word width
- DATA_WIDTH, 32, datapath width; immediate_out and pc_offset_out are sign-extended to this width
- OPCODE_WIDTH, 6, opcode field width (bits [31:26])
- FUNCTION_WIDTH, 6, R-type function field width (bits [5:0])
- REG_ADDR_WIDTH, 5, register address width
- IMEDIATE_WIDTH, 16, immediate field width
- PC_OFFSET_WIDTH, 26, jump offset field width

Ports (clock and reset first):
- clk  in  1  stage clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction_in/pc_in valid
- in_ready  out  1  stage accepts input this cycle (combinational)
- instruction_in  in  INSTRUCTION_WIDTH  instruction word
- pc_in  in  DATA_WIDTH  PC of instruction_in
- flush_in  in  1  kill the held output and any accepted input (taken branch/jump)
- out_ready  in  1  execute stage accepts the output bundle
- out_valid  out  1  output bundle valid
- pc_out  out  DATA_WIDTH  registered PC
- opcode_out  out  OPCODE_WIDTH  registered opcode
- inst_function_out  out  FUNCTION_WIDTH  registered function field, 0 for non-R-type
- reg_rd_addr1_out, reg_rd_addr2_out  out  REG_ADDR_WIDTH  source registers
- reg_rd_en1_out, reg_rd_en2_out  out  1  source read enables
- reg_wr_addr_out  out  REG_ADDR_WIDTH  destination register
- reg_wr_en_out  out  1  register write enable
- immediate_out  out  DATA_WIDTH  sign-extended immediate
- imm_inst_out  out  1  operand B is the immediate
- pc_offset_out  out  DATA_WIDTH  sign-extended 26-bit jump offset
- mem_data_rd_en_out, mem_data_wr_en_out  out  1  load/store
- write_back_mux_sel_out  out  1  1 = memory data written back
- branch_inst_out, jump_inst_out, jump_use_r_out  out  1  control-flow class
- illegal_inst_out  out  1  unknown opcode; bundle is otherwise a NOP
- bubble_count_out  out  16  saturating count of interlock bubbles inserted

## Operation
Field decode per opcode class:
- R-type: rs1=[25:21], rs2=[20:16], rd=[15:11], both reads enabled, write enabled.
- ADDI/SUBI/ANDI/ORI: rs1, rd=[20:16], immediate, write enabled.
- LW: as ALU-immediate, plus mem_data_rd_en=1 and write_back_mux_sel=1.
- SW: rs1, rs2, immediate, mem_data_wr_en=1, no register write.
- BEQZ/BNEZ/BRFL: rs1, immediate, branch=1, no register write.
- JR: rs1, jump=1, jump_use_r=1.
- JPC: pc_offset, jump=1.

All-zero instruction word:
- Valid NOP: every enable 0, illegal_inst_out=0.

Unknown opcode:
- Decoded as a NOP with illegal_inst_out=1.
- out_valid=1, so the fault is seen downstream.

Output register behaviour:
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !rst.
- The register loads the decoded bundle when in_valid && in_ready.
- The register loads a bubble (out_valid=0) when advance and no input is accepted.
- The register holds when !advance.

Hazard (load-use):
- hazard = out_valid && mem_data_rd_en_out && reg_wr_addr_out!=0 && in_valid.
- It also requires that an enabled source of instruction_in equals reg_wr_addr_out.
- On hazard with advance: one bubble is inserted, bubble_count_out increments (saturates at 16'hFFFF), and the input is held upstream.
- The next cycle the held instruction is accepted.

Flush:
- flush_in has priority over everything.
- At the next edge out_valid=0, and the bundle is cleared to NOP values.
- in_ready=1 during flush; any accepted input is discarded.
- bubble_count_out does not increment on flush.

Reset:
- rst has priority over flush.
- All outputs are 0, including bubble_count_out.
- in_ready=0 while rst is high.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction per cycle when there is no hazard and out_ready=1.
- Load-use penalty: exactly 1 bubble cycle.
- Back-pressure (out_ready=0 with out_valid=1): all outputs stable, in_ready=0.
- Simultaneous hazard and flush: flush wins; no bubble is counted.
- in_ready is combinational from out_valid, out_ready, hazard and rst. It has no dependence on flush_in beyond forcing it to 1.

## Configuration
UDLX_LOAD_USE_INTERLOCK_EN:
- Defined: the hazard logic and bubble_count_out behave as above.
- Undefined: hazard is tied to 0, bubble_count_out is tied to 0, and the stage never self-stalls; load-use is left to software scheduling.

## Structure
Shared package holds:
- Opcode constants (R_TYPE, ADDI, SUBI, ANDI, ORI, LW, SW, BEQZ, BNEZ, BRFL, JR, JPC).
- The NOP bundle default.
- Bubble-counter width.

Sub-module decode_fields:
- Purely combinational opcode-to-bundle decoder, including sign extension.
- decode_stage_pipe instantiates it and adds the register, handshake, hazard, flush and counter logic.

## Test plan
- Reset → out_valid=0, all bundle fields 0, bubble_count_out=0, in_ready=0 while rst=1.
- ADDI r2,r1,-4 (0x2022FFFC with the ADDI opcode) followed by ADD r3,r2,r1, with out_ready=1 → first bundle: immediate_out=0xFFFFFFFC, imm_inst_out=1, rd=2. Next cycle: R-type bundle with rd=3, no stall.
- LW r5,0(r1) then ADD r6,r5,r0 → one bubble cycle (out_valid=0, in_ready=0), then the ADD bundle; bubble_count_out=1. With the macro undefined: no bubble, count 0.
- out_ready held 0 for 3 cycles with out_valid=1 → outputs unchanged, in_ready=0; the data resumes in order when released.
- flush_in pulsed while a BEQZ bundle is held and a new instruction is valid → next cycle out_valid=0, the input is consumed and dropped, and the count is unchanged.
- Unknown opcode 6'h3F → out_valid=1, illegal_inst_out=1, all enables 0. All-zero word → out_valid=1, illegal_inst_out=0.
